sbqm_queue_ctrl: RTL and testbench

//  Sequencing controller for the bank queue. Detects customer arrivals on the entry photocell.

---
 rtl/sbqm_queue_ctrl_if.sv | 44 ++++
 rtl/sbqm_queue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sbqm_queue_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sbqm_queue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sbqm_queue_ctrl_if
// Description : Sensor/teller/status bundle for the bank-queue sequencing
//               controller. The wait_time signal exists only when
//               SBQM_WAIT_TIME_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface sbqm_queue_ctrl_if #(
    parameter int N  = 3,
    parameter int T  = 3,
    parameter int TW = 2
);
    logic          entry_sensor;
    logic [T-1:0]  teller_req;
    logic [N-1:0]  Pcount;
    logic          empty_flag;
    logic          full_flag;
    logic [T-1:0]  teller_grant;
    logic [TW-1:0] serve_id;
    logic          entry_reject;
`ifdef SBQM_WAIT_TIME_EN
    logic [N+3:0]  wait_time;
`endif

    // Sensor / teller side: drives the raw inputs, observes queue status.
    modport master (
        output entry_sensor, teller_req,
        input  Pcount, empty_flag, full_flag, teller_grant, serve_id, entry_reject
`ifdef SBQM_WAIT_TIME_EN
        , input wait_time
`endif
    );

    // Controller side.
    modport slave (
        input  entry_sensor, teller_req,
        output Pcount, empty_flag, full_flag, teller_grant, serve_id, entry_reject
`ifdef SBQM_WAIT_TIME_EN
        , output wait_time
`endif
    );
endinterface
`default_nettype wire

// File: rtl/sbqm_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sbqm_queue_ctrl
// Description : Bank-queue sequencing controller. Counts arrivals from the
//               entry photocell, collects teller-free requests and dispatches
//               waiting customers to tellers round-robin (one dispatch per
//               two cycles). Maintains the people count and registered
//               empty/full flags.
//               Optional feature macro: SBQM_WAIT_TIME_EN adds the wait_time
//               output (Pcount * SVC_TIME minutes).
// Revision    : 1.0 - initial release
// ============================================================================
module sbqm_queue_ctrl #(
    parameter int N  = 3,
    parameter int T  = 3,
    parameter int TW = 2
`ifdef SBQM_WAIT_TIME_EN
    , parameter int SVC_TIME = 3
`endif
) (
    input  logic               clk,
    input  logic               reset,
    sbqm_queue_ctrl_if.slave   bus
);

    localparam logic [N-1:0] MAX_COUNT = {N{1'b1}};
    localparam logic [TW:0]  T_WIDE    = (TW+1)'(T);
    localparam logic [TW-1:0] RR_INIT  = TW'(T - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // Input conditioning
    logic         entry_s1, entry_s2, entry_prev;
    logic [T-1:0] req_s1, req_s2, req_prev;
    logic         entry_ev;
    logic [T-1:0] req_ev;

    // Control state
    logic [0:0]    state;
    logic [T-1:0]  pending;
    logic [TW-1:0] rr_ptr;
    logic [N-1:0]  count;
    logic          empty_reg, full_reg;
    logic [T-1:0]  grant_reg;
    logic [TW-1:0] serve_reg;
    logic          reject_reg;

    // Combinational decisions
    logic          win_found;
    logic [TW-1:0] win_idx;
    logic [TW:0]   cand;
    logic          dispatch;
    logic [T-1:0]  grant_mask;
    logic [N-1:0]  count_next;
    logic          reject_next;

    assign entry_ev = entry_s2 & ~entry_prev;
    assign req_ev   = req_s2 & ~req_prev;

    // Two-flop synchronizers plus previous-value registers for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_s1   <= 1'b0;
            entry_s2   <= 1'b0;
            entry_prev <= 1'b0;
            req_s1     <= '0;
            req_s2     <= '0;
            req_prev   <= '0;
        end else begin
            entry_s1   <= bus.entry_sensor;
            entry_s2   <= entry_s1;
            entry_prev <= entry_s2;
            req_s1     <= bus.teller_req;
            req_s2     <= req_s1;
            req_prev   <= req_s2;
        end
    end

    // Round-robin search: first pending teller strictly after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= T; k++) begin
            cand = {1'b0, rr_ptr} + (TW+1)'(k);
            if (cand >= T_WIDE) begin
                cand = cand - T_WIDE;
            end
            if (!win_found && pending[cand[TW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[TW-1:0];
            end
        end
    end

    assign dispatch   = (state == IDLE) && win_found && (count != '0);
    assign grant_mask = dispatch ? (T'(1) << win_idx) : '0;

    // Next count: arrival and dispatch on the same edge cancel, even when full.
    always_comb begin
        count_next  = count;
        reject_next = 1'b0;
        if (entry_ev && !dispatch) begin
            if (count == MAX_COUNT) begin
                reject_next = 1'b1;
            end else begin
                count_next = count + N'(1);
            end
        end else if (!entry_ev && dispatch) begin
            count_next = count - N'(1);
        end
    end

    // Dispatch FSM, pending requests, count and registered flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            rr_ptr     <= RR_INIT;
            count      <= '0;
            empty_reg  <= 1'b1;
            full_reg   <= 1'b0;
            grant_reg  <= '0;
            serve_reg  <= '0;
            reject_reg <= 1'b0;
        end else begin
            // A new request edge wins over the clear of a same-cycle grant.
            pending    <= (pending & ~grant_mask) | req_ev;
            count      <= count_next;
            empty_reg  <= (count_next == '0);
            full_reg   <= (count_next == MAX_COUNT);
            reject_reg <= reject_next;
            grant_reg  <= grant_mask;
            serve_reg  <= dispatch ? win_idx : '0;
            case (state)
                IDLE: begin
                    if (dispatch) begin
                        state  <= GRANT;
                        rr_ptr <= win_idx;
                    end
                end
                GRANT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Pcount       = count;
    assign bus.empty_flag   = empty_reg;
    assign bus.full_flag    = full_reg;
    assign bus.teller_grant = grant_reg;
    assign bus.serve_id     = serve_reg;
    assign bus.entry_reject = reject_reg;

`ifdef SBQM_WAIT_TIME_EN
    logic [N+3:0] wait_reg;

    // Estimated wait tracks the count on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_reg <= '0;
        end else begin
            wait_reg <= (N+4)'(count_next) * (N+4)'(SVC_TIME);
        end
    end

    assign bus.wait_time = wait_reg;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sbqm_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sbqm_queue_ctrl
// Description : Directed self-checking bench for sbqm_queue_ctrl
//               (N=3, T=3, TW=2; SVC_TIME=3 when SBQM_WAIT_TIME_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sbqm_queue_ctrl;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    sbqm_queue_ctrl_if #(.N(3), .T(3), .TW(2)) bus ();

    sbqm_queue_ctrl #(.N(3), .T(3), .TW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus.entry_sensor = 1'b0;
        bus.teller_req   = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // One arrival: count updates on the third edge after raising the sensor.
    task automatic entry_pulse();
        bus.entry_sensor = 1'b1;
        repeat (3) tick();
        bus.entry_sensor = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_wait(input string tag, input logic [31:0] exp);
`ifdef SBQM_WAIT_TIME_EN
        check(tag, 32'(bus.wait_time), exp);
`else
        if (exp > 32'd1000) $display("unexpected wait request %s", tag);
`endif
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check("rst_pcount", 32'(bus.Pcount), 0);
        check("rst_empty",  32'(bus.empty_flag), 1);
        check("rst_full",   32'(bus.full_flag), 0);
        check("rst_grant",  32'(bus.teller_grant), 0);
        check("rst_serve",  32'(bus.serve_id), 0);
        check("rst_reject", 32'(bus.entry_reject), 0);
        check_wait("rst_wait", 0);

        // ---------------- test 1: arrivals, latency ----------------
        bus.entry_sensor = 1'b1;
        tick(); tick();
        check("t1_lat_pcount", 32'(bus.Pcount), 0);
        check("t1_lat_empty",  32'(bus.empty_flag), 1);
        tick();
        check("t1_pcount1", 32'(bus.Pcount), 1);
        check("t1_empty1",  32'(bus.empty_flag), 0);
        bus.entry_sensor = 1'b0;
        repeat (3) tick();
        entry_pulse();
        check("t1_pcount2", 32'(bus.Pcount), 2);
        entry_pulse();
        check("t1_pcount3", 32'(bus.Pcount), 3);
        check_wait("t1_wait3", 9);

        // ---------------- test 2: fill and reject ----------------
        entry_pulse();
        entry_pulse();
        check("t2_pcount5", 32'(bus.Pcount), 5);
        check_wait("t2_wait5", 15);
        entry_pulse();
        entry_pulse();
        check("t2_pcount7", 32'(bus.Pcount), 7);
        check("t2_full",    32'(bus.full_flag), 1);
        check("t2_empty",   32'(bus.empty_flag), 0);
        check_wait("t2_wait7", 21);
        bus.entry_sensor = 1'b1;
        repeat (3) tick();
        check("t2_reject_hi", 32'(bus.entry_reject), 1);
        check("t2_pcount_hold", 32'(bus.Pcount), 7);
        tick();
        check("t2_reject_lo", 32'(bus.entry_reject), 0);
        bus.entry_sensor = 1'b0;
        repeat (3) tick();

        // ---------------- test 5: arrival with dispatch at full ----------------
        bus.teller_req = 3'b001;
        tick();
        bus.entry_sensor = 1'b1;
        repeat (3) tick();
        check("t5_pcount",  32'(bus.Pcount), 7);
        check("t5_reject",  32'(bus.entry_reject), 0);
        check("t5_grant",   32'(bus.teller_grant), 3'b001);
        check("t5_serve",   32'(bus.serve_id), 0);
        check("t5_full",    32'(bus.full_flag), 1);
        tick();
        check("t5_grant_end", 32'(bus.teller_grant), 0);
        bus.entry_sensor = 1'b0;
        bus.teller_req   = '0;
        repeat (4) tick();

        // ---------------- test 3: round robin on all tellers ----------------
        do_reset();
        repeat (3) entry_pulse();
        check("t3_pcount3", 32'(bus.Pcount), 3);
        bus.teller_req = 3'b111;
        repeat (3) tick();
        check("t3_nogrant_yet", 32'(bus.teller_grant), 0);
        tick();
        check("t3_grant0",  32'(bus.teller_grant), 3'b001);
        check("t3_serve0",  32'(bus.serve_id), 0);
        check("t3_pcount2", 32'(bus.Pcount), 2);
        tick();
        check("t3_gap0", 32'(bus.teller_grant), 0);
        check("t3_gap0_serve", 32'(bus.serve_id), 0);
        tick();
        check("t3_grant1",  32'(bus.teller_grant), 3'b010);
        check("t3_serve1",  32'(bus.serve_id), 1);
        check("t3_pcount1", 32'(bus.Pcount), 1);
        tick(); tick();
        check("t3_grant2",  32'(bus.teller_grant), 3'b100);
        check("t3_serve2",  32'(bus.serve_id), 2);
        check("t3_pcount0", 32'(bus.Pcount), 0);
        check("t3_empty",   32'(bus.empty_flag), 1);
        check_wait("t3_wait0", 0);
        tick();
        check("t3_done", 32'(bus.teller_grant), 0);
        bus.teller_req = '0;
        repeat (4) tick();

        // ---------------- test 4: request while empty ----------------
        bus.teller_req = 3'b010;
        repeat (6) tick();
        check("t4_no_grant", 32'(bus.teller_grant), 0);
        check("t4_pcount0",  32'(bus.Pcount), 0);
        bus.entry_sensor = 1'b1;
        repeat (3) tick();
        check("t4_pcount1", 32'(bus.Pcount), 1);
        tick();
        check("t4_grant1",  32'(bus.teller_grant), 3'b010);
        check("t4_serve1",  32'(bus.serve_id), 1);
        check("t4_pcount0b", 32'(bus.Pcount), 0);
        check("t4_empty",   32'(bus.empty_flag), 1);
        bus.entry_sensor = 1'b0;
        bus.teller_req   = '0;
        repeat (4) tick();

        // ---------------- test 6: reset during grant ----------------
        do_reset();
        repeat (3) entry_pulse();
        bus.teller_req = 3'b111;
        repeat (4) tick();
        check("t6_grant0", 32'(bus.teller_grant), 3'b001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_grant_cut", 32'(bus.teller_grant), 0);
        check("t6_pcount",    32'(bus.Pcount), 0);
        check("t6_empty",     32'(bus.empty_flag), 1);
        check("t6_full",      32'(bus.full_flag), 0);
        check("t6_serve",     32'(bus.serve_id), 0);
        check("t6_reject",    32'(bus.entry_reject), 0);
        bus.entry_sensor = 1'b1;
        repeat (3) tick();
        check("t6_pcount1",   32'(bus.Pcount), 1);
        check("t6_no_early",  32'(bus.teller_grant), 0);
        tick();
        check("t6_regrant0",  32'(bus.teller_grant), 3'b001);
        check("t6_reserve0",  32'(bus.serve_id), 0);
        bus.entry_sensor = 1'b0;
        bus.teller_req   = '0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
